// File: rtl/ysyx_24100006_trap_ctrl_if.sv
// Trap controller bus: trap/mret requests, CSR-instruction writes, CSR file port and IFU redirect.
// The master modport is the trap controller; slave is the surrounding pipeline/CSR file/IFU.
interface ysyx_24100006_trap_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  trap_valid;
  logic [DATA_WIDTH-1:0] trap_pc;
  logic [DATA_WIDTH-1:0] trap_cause;
  logic                  mret_valid;
  logic                  trap_ack;
  logic                  inst_wen;
  logic [ADDR_WIDTH-1:0] inst_waddr;
  logic [DATA_WIDTH-1:0] inst_wdata;
  logic                  inst_ready;
  logic                  csr_wen;
  logic [ADDR_WIDTH-1:0] csr_waddr;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic [DATA_WIDTH-1:0] mtvec;
  logic [DATA_WIDTH-1:0] mepc;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  redirect_ready;
  logic                  busy;
  logic [7:0]            trap_cnt;

  modport master (
    input  trap_valid, trap_pc, trap_cause, mret_valid,
    input  inst_wen, inst_waddr, inst_wdata,
    input  mtvec, mepc, redirect_ready,
    output trap_ack, inst_ready, csr_wen, csr_waddr, csr_wdata,
    output redirect_valid, redirect_pc, busy, trap_cnt
  );

  modport slave (
    output trap_valid, trap_pc, trap_cause, mret_valid,
    output inst_wen, inst_waddr, inst_wdata,
    output mtvec, mepc, redirect_ready,
    input  trap_ack, inst_ready, csr_wen, csr_waddr, csr_wdata,
    input  redirect_valid, redirect_pc, busy, trap_cnt
  );
endinterface

// File: rtl/ysyx_24100006_trap_ctrl.sv
// Trap/mret sequencer: serialises mepc/mcause/mstatus CSR writes, then redirects the IFU.
// CSR-instruction writes pass straight through only while the sequencer is idle.
module ysyx_24100006_trap_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                       clk,
  input logic                       rst_n,
  ysyx_24100006_trap_ctrl_if.master bus
);

  localparam int unsigned CNT_WIDTH = 8;
  localparam logic [ADDR_WIDTH-1:0] A_MSTATUS = ADDR_WIDTH'(12'h300);
  localparam logic [ADDR_WIDTH-1:0] A_MEPC    = ADDR_WIDTH'(12'h341);
  localparam logic [ADDR_WIDTH-1:0] A_MCAUSE  = ADDR_WIDTH'(12'h342);
  localparam logic [DATA_WIDTH-1:0] ST_TRAP   = DATA_WIDTH'(32'h0000_1800);
  localparam logic [DATA_WIDTH-1:0] ST_MRET   = DATA_WIDTH'(32'h0000_1880);

  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, W_MRET, REDIR} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, cause_q, target_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  take_trap, take_mret;
  logic                  ack, ready, wen, rvalid, busy;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  // State register and latched sequence operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (take_trap) begin
        pc_q    <= bus.trap_pc;
        cause_q <= bus.trap_cause;
        cnt_q   <= cnt_q + CNT_WIDTH'(1);
      end
      if (take_mret) target_q <= bus.mepc;
      if (state_q == W_STATUS) target_q <= bus.mtvec;
    end
  end

  // Next state and outputs; everything is held low while reset is asserted
  always_comb begin
    state_d   = state_q;
    take_trap = 1'b0;
    take_mret = 1'b0;
    ack       = 1'b0;
    ready     = 1'b0;
    wen       = 1'b0;
    waddr     = '0;
    wdata     = '0;
    rvalid    = 1'b0;
    busy      = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (bus.trap_valid) begin
            ack       = 1'b1;
            take_trap = 1'b1;
            state_d   = W_EPC;
          end else if (bus.mret_valid) begin
            ack       = 1'b1;
            take_mret = 1'b1;
            state_d   = W_MRET;
          end else begin
            ready = 1'b1;
            wen   = bus.inst_wen;
            waddr = bus.inst_waddr;
            wdata = bus.inst_wdata;
          end
        end
        W_EPC: begin
          busy    = 1'b1;
          wen     = 1'b1;
          waddr   = A_MEPC;
          wdata   = pc_q;
          state_d = W_CAUSE;
        end
        W_CAUSE: begin
          busy    = 1'b1;
          wen     = 1'b1;
          waddr   = A_MCAUSE;
          wdata   = cause_q;
          state_d = W_STATUS;
        end
        W_STATUS: begin
          busy    = 1'b1;
          wen     = 1'b1;
          waddr   = A_MSTATUS;
          wdata   = ST_TRAP;
          state_d = REDIR;
        end
        W_MRET: begin
          busy    = 1'b1;
          wen     = 1'b1;
          waddr   = A_MSTATUS;
          wdata   = ST_MRET;
          state_d = REDIR;
        end
        REDIR: begin
          busy   = 1'b1;
          rvalid = 1'b1;
          if (bus.redirect_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.trap_ack       = ack;
  assign bus.inst_ready     = ready;
  assign bus.csr_wen        = wen;
  assign bus.csr_waddr      = waddr;
  assign bus.csr_wdata      = wdata;
  assign bus.redirect_valid = rvalid;
  assign bus.redirect_pc    = target_q & ~DATA_WIDTH'(3);
  assign bus.busy           = busy;
  assign bus.trap_cnt       = cnt_q;

endmodule
